ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h8000_0000, PC loaded on reset.
REQ-002 SHALL have parameter: TIMEOUT, 255, maximum cycles spent waiting on the memory read response.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports listed below, clock and reset first.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 araddr  out  32  instruction fetch address (= pc).
REQ-007 arvalid  out  1  read-address request valid.
REQ-008 arready  in  1  memory accepts address.
REQ-009 rdata  in  32  fetched word.
REQ-010 rresp  in  2  response code; 2'b00 = OKAY, anything else = error.
REQ-011 rvalid  in  1  read-data valid.
REQ-012 rready  out  1  fetch unit accepts data.
REQ-013 inst  out  32  instruction to the decoder.
REQ-014 pc  out  32  address of inst.
REQ-015 inst_valid  out  1  inst/pc hold a fetched instruction.
REQ-016 inst_ready  in  1  decoder/execute consumes inst.
REQ-017 next_pc  in  32  next PC from the PC-select muxes.
REQ-018 next_pc_valid  in  1  next_pc is final for this instruction.
REQ-019 fetch_err  out  1  sticky fetch fault flag.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, VALID, NEXT, HALT.
REQ-021 IDLE SHALL assert no outputs and SHALL go to REQ on the next edge.
REQ-022 REQ SHALL assert arvalid with araddr=pc, and SHALL go to WAIT on arvalid&&arready.
REQ-023 araddr SHALL be held stable while arvalid is high.
REQ-024 WAIT SHALL assert rready and SHALL count cycles in a counter ($clog2(TIMEOUT+1) bits) that clears on WAIT entry.
REQ-025 On rvalid in WAIT with rresp==2'b00: inst<=rdata, then go to VALID.
REQ-026 On rvalid in WAIT with rresp!=2'b00: inst<=32'h0, fetch_err<=1, then go to VALID.
REQ-027 If the WAIT counter reaches TIMEOUT without rvalid: inst<=32'h0, fetch_err<=1, then go to VALID; a later rvalid SHALL be ignored.
REQ-028 VALID SHALL assert inst_valid, hold inst and pc stable, and go to NEXT on inst_valid&&inst_ready.
REQ-029 NEXT SHALL drive inst_valid=0; on next_pc_valid with next_pc[1:0]==2'b00 it SHALL set pc<=next_pc and go to REQ.
REQ-030 In NEXT, next_pc_valid with next_pc[1:0]!=2'b00 SHALL set fetch_err<=1, leave pc unchanged, and go to HALT.
REQ-031 HALT SHALL be terminal until reset: arvalid=rready=inst_valid=0.
REQ-032 Minimum fetch latency SHALL be 2 cycles (REQ→WAIT→VALID) from REQ entry with arready and rvalid each high on first opportunity; there SHALL be one cycle in NEXT per instruction minimum.
REQ-033 Inputs SHALL be ignored in states where they are not named above: arready outside REQ, rvalid outside WAIT, inst_ready outside VALID, next_pc_valid outside NEXT.
REQ-034 fetch_err SHALL be sticky; only rst clears it.

Reset
REQ-035 While rst=1 (async assert): state=IDLE, pc=RESET_PC, inst=32'h0, counter=0, fetch_err=0, arvalid=rready=inst_valid=0.
REQ-036 Reset mid-transaction SHALL abandon the transaction; after deassertion a fresh fetch SHALL issue at RESET_PC with no stale inst_valid.

Verification
REQ-037 Release rst, memory responds with zero wait and rdata=32'h00500093 -> arvalid in cycle 2 with araddr=32'h8000_0000, inst_valid in cycle 4, inst=32'h00500093.
REQ-038 arready delayed 3 cycles, rvalid delayed 5 cycles -> araddr stable throughout, inst_valid only after rvalid, fetch_err=0.
REQ-039 next_pc=32'h8000_0010 with next_pc_valid in NEXT -> next araddr=32'h8000_0010 and pc=32'h8000_0010 with the new inst.
REQ-040 rresp=2'b10 -> inst=32'h0, inst_valid=1, fetch_err=1 and held through the following fetches.
REQ-041 rvalid never arrives -> after 255 WAIT cycles inst=0 with fetch_err=1; a late rvalid is ignored.
REQ-042 next_pc=32'h8000_0002 -> HALT with no further arvalid and fetch_err=1; rst asserted in WAIT -> outputs reset immediately and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundle of the fetch unit's memory-read and decoder-side signals.
//   master : fetch unit (drives araddr/arvalid/rready and the inst/pc/inst_valid/fetch_err
//            handoff to decode; consumes arready/rdata/rresp/rvalid/inst_ready/next_pc*).
//   slave  : memory plus decode/PC-select environment (mirror image of master).
interface ifu_fetch_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        fetch_err;

  modport master (
    output araddr, arvalid, rready, inst, pc, inst_valid, fetch_err,
    input  arready, rdata, rresp, rvalid, inst_ready, next_pc, next_pc_valid
  );

  modport slave (
    input  araddr, arvalid, rready, inst, pc, inst_valid, fetch_err,
    output arready, rdata, rresp, rvalid, inst_ready, next_pc, next_pc_valid
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
//   clk  : sole clock, rising edge.
//   rst  : asynchronous active-high reset.
//   bus  : ifu_fetch_if.master -- read-address/read-data handshake to memory, instruction
//          handoff (inst/pc/inst_valid/inst_ready) to decode, next_pc/next_pc_valid from the
//          PC-select logic, and the sticky fetch_err flag.
// One fetch is in flight at a time: request pc, wait for data (bounded by TIMEOUT cycles),
// present the word, then wait for the next PC. A misaligned next PC halts until reset.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StValid,
    StNext,
    StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    bus.inst_valid = 1'b0;

    unique case (state_q)
      StIdle: state_d = StReq;

      StReq: begin
        bus.arvalid = 1'b1;
        if (bus.arready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end

      StWait: begin
        bus.rready = 1'b1;
        cnt_d      = cnt_q + CntW'(1);
        if (bus.rvalid) begin
          state_d = StValid;
          if (bus.rresp == 2'b00) begin
            inst_d = bus.rdata;
          end else begin
            inst_d = 32'h0;
            err_d  = 1'b1;
          end
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Last permitted WAIT cycle passed with no data: give up; any later rvalid is
          // dropped because we are no longer in WAIT.
          state_d = StValid;
          inst_d  = 32'h0;
          err_d   = 1'b1;
        end
      end

      StValid: begin
        bus.inst_valid = 1'b1;
        if (bus.inst_ready) state_d = StNext;
      end

      StNext: begin
        if (bus.next_pc_valid) begin
          if (bus.next_pc[1:0] == 2'b00) begin
            pc_d    = bus.next_pc;
            state_d = StReq;
          end else begin
            err_d   = 1'b1;
            state_d = StHalt;
          end
        end
      end

      StHalt: state_d = StHalt;

      default: state_d = StIdle;
    endcase
  end

  assign bus.araddr    = pc_q;
  assign bus.pc        = pc_q;
  assign bus.inst      = inst_q;
  assign bus.fetch_err = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: the bench plays memory and decode with random delays
// and noise on inputs the current phase should ignore, and predicts pc/inst/fetch_err and
// the number of WAIT cycles from the fetch rules.
module tb_ifu_fetch;

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam int unsigned Timeout = 255;

  logic clk = 1'b0;
  logic rst;

  ifu_fetch_if bus ();

  ifu_fetch #(
    .RESET_PC(ResetPc),
    .TIMEOUT (Timeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] exp_pc;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet_inputs();
    bus.arready       = 1'b0;
    bus.rdata         = 32'h0;
    bus.rresp         = 2'b00;
    bus.rvalid        = 1'b0;
    bus.inst_ready    = 1'b0;
    bus.next_pc       = 32'h0;
    bus.next_pc_valid = 1'b0;
  endtask

  // Request, optional arready stall, data wait (rvalid at WAIT cycle r_dly), then check the
  // presented instruction. r_dly >= Timeout means the data never comes in time.
  task automatic fetch_resp(input int ar_dly, input int r_dly, input logic [1:0] resp,
                            input logic [31:0] word);
    int          n;
    bit          ok;
    int          exp_wait;
    logic [31:0] exp_inst;
    n = 0;
    while (bus.arvalid !== 1'b1 && n < 8) begin
      bus.rvalid     = 1'($urandom);
      bus.inst_ready = 1'($urandom);
      tick();
      n++;
    end
    check("arvalid_seen", 32'(bus.arvalid), 32'd1);
    if (bus.arvalid !== 1'b1) return;
    check("araddr", bus.araddr, exp_pc);
    for (int i = 0; i < ar_dly; i++) begin
      bus.arready       = 1'b0;
      bus.rvalid        = 1'($urandom);
      bus.rdata         = $urandom;
      bus.inst_ready    = 1'($urandom);
      bus.next_pc_valid = 1'($urandom);
      bus.next_pc       = exp_pc + 32'd2;
      tick();
      check("arvalid_hold", 32'(bus.arvalid), 32'd1);
      check("araddr_hold", bus.araddr, exp_pc);
    end
    quiet_inputs();
    bus.arready = 1'b1;
    tick();
    ok       = (r_dly < int'(Timeout));
    exp_wait = ok ? r_dly + 1 : int'(Timeout);
    n = 0;
    while (bus.rready === 1'b1 && n < int'(Timeout) + 8) begin
      bus.arready       = 1'($urandom);
      bus.inst_ready    = 1'($urandom);
      bus.next_pc_valid = 1'($urandom);
      bus.next_pc       = $urandom | 32'h1;
      bus.rvalid        = (n == r_dly);
      bus.rresp         = resp;
      bus.rdata         = (n == r_dly) ? word : $urandom;
      tick();
      n++;
    end
    quiet_inputs();
    check("wait_cycles", 32'(n), 32'(exp_wait));
    if (!ok || resp != 2'b00) exp_err = 1'b1;
    exp_inst = (ok && resp == 2'b00) ? word : 32'h0;
    check("inst_valid", 32'(bus.inst_valid), 32'd1);
    check("inst", bus.inst, exp_inst);
    check("pc", bus.pc, exp_pc);
    check("fetch_err", 32'(bus.fetch_err), 32'(exp_err));
    check("valid_no_req", 32'({bus.arvalid, bus.rready}), 32'd0);
  endtask

  // Hold VALID for v_dly cycles with noise, then hand the instruction over.
  task automatic consume(input int v_dly);
    logic [31:0] held;
    held = bus.inst;
    for (int i = 0; i < v_dly; i++) begin
      bus.inst_ready    = 1'b0;
      bus.rvalid        = 1'b1;
      bus.rresp         = 2'($urandom);
      bus.rdata         = $urandom;
      bus.arready       = 1'($urandom);
      bus.next_pc_valid = 1'($urandom);
      bus.next_pc       = $urandom | 32'h1;
      tick();
      check("valid_hold", 32'(bus.inst_valid), 32'd1);
      check("inst_hold", bus.inst, held);
      check("pc_hold", bus.pc, exp_pc);
    end
    quiet_inputs();
    bus.inst_ready = 1'b1;
    tick();
    quiet_inputs();
    check("next_no_valid", 32'({bus.inst_valid, bus.arvalid, bus.rready}), 32'd0);
  endtask

  // Sit in NEXT for n_dly cycles, then present next PC.
  task automatic do_next(input int n_dly, input logic [31:0] np);
    for (int i = 0; i < n_dly; i++) begin
      bus.inst_ready = 1'($urandom);
      bus.rvalid     = 1'($urandom);
      bus.arready    = 1'($urandom);
      tick();
      check("next_idle", 32'({bus.inst_valid, bus.arvalid, bus.rready}), 32'd0);
    end
    quiet_inputs();
    bus.next_pc_valid = 1'b1;
    bus.next_pc       = np;
    tick();
    quiet_inputs();
    if (np[1:0] == 2'b00) exp_pc = np;
    else exp_err = 1'b1;
  endtask

  task automatic rand_fetch(input bit allow_err);
    logic [1:0] resp;
    resp = 2'b00;
    if (allow_err && $urandom_range(0, 3) == 0) resp = 2'($urandom_range(1, 3));
    fetch_resp(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), resp, $urandom);
    consume(int'($urandom_range(0, 3)));
    do_next(int'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFFC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    quiet_inputs();
    rst     = 1'b1;
    exp_pc  = ResetPc;
    exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_rready", 32'(bus.rready), 32'd0);
    check("rst_ivalid", 32'(bus.inst_valid), 32'd0);
    check("rst_pc", bus.pc, ResetPc);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_err", 32'(bus.fetch_err), 32'd0);

    // Zero-wait first fetch: arvalid in cycle 2, inst_valid in cycle 4.
    rst = 1'b0;
    cyc = 0;
    check("c1_idle", 32'(bus.arvalid), 32'd0);
    tick();
    check("c2_arvalid", 32'(bus.arvalid), 32'd1);
    fetch_resp(0, 0, 2'b00, 32'h0050_0093);
    check("c4_latency", 32'(cyc), 32'd3);
    consume(0);
    do_next(0, 32'h8000_0010);

    // Jump target fetched next, with stalled arready and late rvalid.
    fetch_resp(3, 5, 2'b00, $urandom);
    consume(2);
    do_next(1, exp_pc + 32'd4);

    for (int i = 0; i < 25; i++) rand_fetch(1'b0);
    check("err_clean", 32'(bus.fetch_err), 32'd0);

    // Error response, then sticky through further fetches.
    fetch_resp(1, 2, 2'b10, 32'hDEAD_BEEF);
    consume(1);
    do_next(0, $urandom & 32'hFFFF_FFFC);
    for (int i = 0; i < 15; i++) rand_fetch(1'b1);

    // rvalid on the last permitted WAIT cycle is still taken; one cycle later is a timeout.
    fetch_resp(0, int'(Timeout) - 1, 2'b00, 32'h1234_5678);
    consume(0);
    do_next(0, $urandom & 32'hFFFF_FFFC);
    fetch_resp(0, int'(Timeout) + 40, 2'b00, 32'hCAFE_F00D);
    consume(4);
    do_next(0, 32'h8000_1000 | ($urandom & 32'h0000_0FFC));

    // Asynchronous reset while in WAIT.
    fetch_resp(0, int'(Timeout) + 40, 2'b00, 32'h0);
    consume(0);
    do_next(0, 32'h8000_2000);
    while (bus.arvalid !== 1'b1 && cyc < 60000) tick();
    bus.arready = 1'b1;
    tick();
    quiet_inputs();
    check("pre_rst_wait", 32'(bus.rready), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_rready", 32'(bus.rready), 32'd0);
    check("arst_arvalid", 32'(bus.arvalid), 32'd0);
    check("arst_pc", bus.pc, ResetPc);
    check("arst_err", 32'(bus.fetch_err), 32'd0);
    check("arst_inst", bus.inst, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_pc  = ResetPc;
    exp_err = 1'b0;
    check("restart_ivalid", 32'(bus.inst_valid), 32'd0);
    fetch_resp(2, 1, 2'b00, $urandom);
    consume(0);

    // Misaligned next PC halts for good.
    do_next(1, 32'h8000_0002);
    for (int i = 0; i < 12; i++) begin
      bus.arready       = 1'($urandom);
      bus.rvalid        = 1'($urandom);
      bus.inst_ready    = 1'($urandom);
      bus.next_pc_valid = 1'($urandom);
      bus.next_pc       = $urandom & 32'hFFFF_FFFC;
      tick();
      check("halt_quiet", 32'({bus.arvalid, bus.rready, bus.inst_valid}), 32'd0);
    end
    check("halt_err", 32'(bus.fetch_err), 32'(exp_err));
    check("halt_pc", bus.pc, exp_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
